i2c_slave_tx_burst: RTL
=======================

# i2c_slave_tx_burst

Parametrised I2C slave transmitter for read transactions: after address match, it shifts out a stream of bytes MSB-first on SDA, samples the master's ACK/NACK after each byte and fetches the next byte through a valid/ready handshake. It sits between the slave address/control FSM, which asserts `enable`, and the local register/FIFO source that supplies bytes. It generalises the single-byte, bit-serial slave writer with:
- parallel byte loading
- multi-byte bursts
- ACK handling
- STOP/abort detection
- optional clock stretching

## Interface
Parameters:
- SYNC_STAGES, 2, synchroniser depth for `scl` and `sda_in` (1..3)
- COUNT_WIDTH, 8, width of `byte_count`; saturates at all-ones

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous, active-low reset
- enable  input  1  level; high = transfer granted by control FSM
- data_in  input  8  next byte to transmit
- data_valid  input  1  `data_in` valid
- data_ready  output  1  block accepts `data_in` this cycle when valid
- scl  input  1  SCL pin level
- sda_in  input  1  SDA pin level
- sda_oe  output  1  1 = pull SDA low (open drain)
- scl_oe  output  1  1 = pull SCL low (stretch; constant 0 without macro)
- busy  output  1  state != IDLE
- done  output  1  one-clk pulse: burst ended by NACK
- nack  output  1  sticky, set on NACK, cleared when next burst starts
- underrun  output  1  sticky, set when a byte was not ready in time, cleared when next burst starts
- byte_count  output  COUNT_WIDTH  ACKed bytes in current/last burst

## Operation
- `scl` and `sda_in` pass through SYNC_STAGES flops. Edges are detected on synchronised values (previous-state register, reset to 1).
- States: IDLE, LOAD, SHIFT, ACK, STRETCH.
- IDLE: `enable`=1 coincident with a detected SCL falling edge moves to LOAD. This clears `nack`, `underrun` and `byte_count`.
- LOAD:
  - `data_ready`=1.
  - On `data_valid&data_ready`: byte goes to shift register, bit counter set to 0, next state SHIFT, and `sda_oe`=~byte[7] from the next clk.
  - If an SCL rising edge arrives first, the byte was late:
    - With macro: not reached; see STRETCH.
    - Without macro: shift register loads 8'hFF (SDA released), `underrun` set, state SHIFT. A byte arriving later in that bit time is discarded.
- SHIFT: each SCL falling edge shifts left and increments the bit counter. After the 8th falling edge: `sda_oe`=0, state ACK.
- ACK: on SCL rising edge, sample synchronised SDA.
  - 0 (ACK): `byte_count`++ (saturating). On the following SCL falling edge, state LOAD.
  - 1 (NACK): `nack`=1, `done` pulse, `sda_oe`=0, state IDLE.
- Abort, from any non-IDLE state, with no `done`:
  - `enable`=0, or a STOP (synchronised SDA rising while SCL high) → IDLE next clk.
  - Releases `sda_oe`/`scl_oe`, `data_ready`=0.
  - `byte_count` keeps its value.
- `data_ready` is high only in LOAD/STRETCH; never high in IDLE, SHIFT or ACK.
- Reset mid-transfer: all outputs to reset values immediately; SDA/SCL released.

## Timing
- Reset values: `sda_oe`=0, `scl_oe`=0, `data_ready`=0, `busy`=0, `done`=0, `nack`=0, `underrun`=0, `byte_count`=0.
- Edge detection latency: SYNC_STAGES+1 clk after the pin edge.
- `sda_oe` updates 1 clk after a detected falling edge, or 1 clk after the LOAD handshake.
- Requirement: SCL low phase ≥ SYNC_STAGES+2 clk; default 4 clk (divider 8).
- `done` is asserted the clk after the NACK-sampling edge detection, for exactly 1 clk.
- Handshake and SCL rising edge in the same clk: the handshake wins; the byte is accepted, with no underrun.
- STOP and ACK sample in the same clk: STOP wins.

## Configuration
- Macro: `I2C_SLAVE_CLOCK_STRETCH_EN`.
- Defined:
  - In LOAD, if no byte is accepted within 1 clk of entry, go to STRETCH.
  - STRETCH: `scl_oe`=1 and `data_ready`=1. On handshake: `sda_oe` set, `scl_oe`=0 one clk later, state SHIFT.
  - `underrun` never sets.
  - Abort rules apply in STRETCH.
- Undefined: STRETCH state absent, `scl_oe` tied 0, underrun path active.

## Test plan
- Burst 0x13,0x57,0x9B,0xDF with immediate `data_valid`, master ACKs the first 3 and NACKs the 4th → 32 bits match MSB-first on SCL high, `byte_count`=3, `nack`=1, one `done` pulse.
- Single byte 0xA5 then NACK → SDA released in bit 9, `done` at NACK+1 clk, back to IDLE, `busy`=0.
- `data_valid` withheld for 20 clk before byte 2:
  - With macro: SCL held low 20+ clk, then byte 0x3C correct, `underrun`=0.
  - Without macro: byte 2 reads 0xFF, `underrun`=1.
- STOP issued (SDA rising, SCL high) during bit 4 of byte 1 → IDLE next clk, `sda_oe`=0, no `done`, `byte_count`=0.
- `enable` dropped after 2 ACKed bytes → immediate release, `byte_count`=2; a new burst clears it to 0 and clears `nack`/`underrun`.
- `rst_n` pulsed low during bit 6 → all outputs at reset values asynchronously, SDA/SCL released.

Source files
------------

// File: rtl/i2c_slave_tx_burst.sv
// Purpose : I2C slave read-data transmitter; shifts bytes MSB-first, samples ACK/NACK and fetches the next byte via valid/ready.
// Latency : pin edges act SYNC_STAGES+1 clk later; sda_oe moves 1 clk after a detected SCL fall or after the byte handshake.
// Backpress: data_ready only in LOAD/STRETCH; a late byte gives 0xFF + underrun, or SCL stretching when I2C_SLAVE_CLOCK_STRETCH_EN is defined.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   enable                         transfer granted by the address/control FSM (dropping it aborts)
//   data_in/data_valid/data_ready  byte source handshake
//   scl, sda_in                    bus pin levels (asynchronous)
//   sda_oe, scl_oe                 open-drain pull-downs (scl_oe is tied 0 unless the macro is defined)
//   busy, done, nack, underrun     status; done is a 1-clk pulse on the NACK that ends a burst
//   byte_count                     ACKed bytes in the current/last burst, saturating
`timescale 1ns/1ps
module i2c_slave_tx_burst #(
  parameter int SYNC_STAGES = 2,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   enable,
  input  logic [7:0]             data_in,
  input  logic                   data_valid,
  output logic                   data_ready,
  input  logic                   scl,
  input  logic                   sda_in,
  output logic                   sda_oe,
  output logic                   scl_oe,
  output logic                   busy,
  output logic                   done,
  output logic                   nack,
  output logic                   underrun,
  output logic [COUNT_WIDTH-1:0] byte_count
);

  typedef enum logic [2:0] {IDLE, LOAD, SHIFT, ACK, STRETCH} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_prev, sda_prev;
  logic [6:0]             shreg;     // remaining bits; bit 7 goes straight to sda_oe on load
  logic [2:0]             bit_cnt;
  logic                   acked;     // ACK seen in this ACK slot, waiting for the closing fall

  logic scl_s, sda_s, scl_fall, scl_rise, stop_det, hs, abort;

  assign scl_s    = scl_sync[SYNC_STAGES-1];
  assign sda_s    = sda_sync[SYNC_STAGES-1];
  assign scl_fall = scl_prev & ~scl_s;
  assign scl_rise = ~scl_prev & scl_s;
  assign stop_det = ~sda_prev & sda_s & scl_s;
  assign hs       = data_valid & data_ready;
  assign abort    = (state != IDLE) & (~enable | stop_det);

  assign data_ready = (state == LOAD) | (state == STRETCH);
  assign busy       = (state != IDLE);

  // Synchronisers and previous-value registers idle high like the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync[0] <= scl;
      sda_sync[0] <= sda_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        scl_sync[i] <= scl_sync[i-1];
        sda_sync[i] <= sda_sync[i-1];
      end
      scl_prev <= scl_s;
      sda_prev <= sda_s;
    end
  end

`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
  logic scl_oe_r;
  assign scl_oe = scl_oe_r;
`else
  assign scl_oe = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      acked      <= 1'b0;
      sda_oe     <= 1'b0;
      done       <= 1'b0;
      nack       <= 1'b0;
      underrun   <= 1'b0;
      byte_count <= '0;
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
      scl_oe_r   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Abort (enable low or STOP) beats any same-cycle event, including the ACK sample.
        state  <= IDLE;
        sda_oe <= 1'b0;
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
        scl_oe_r <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (enable && scl_fall) begin
              state      <= LOAD;
              nack       <= 1'b0;
              underrun   <= 1'b0;
              byte_count <= '0;
            end
          end
          LOAD: begin
            if (hs) begin
              shreg   <= data_in[6:0];
              sda_oe  <= ~data_in[7];
              bit_cnt <= '0;
              state   <= SHIFT;
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
            end else begin
              state    <= STRETCH;
              scl_oe_r <= 1'b1;
            end
`else
            end else if (scl_rise) begin
              // Byte missed the first bit: send all-ones (SDA released) for this slot.
              shreg    <= 7'h7F;
              sda_oe   <= 1'b0;
              bit_cnt  <= '0;
              underrun <= 1'b1;
              state    <= SHIFT;
            end
`endif
          end
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
          STRETCH: begin
            if (hs) begin
              shreg   <= data_in[6:0];
              sda_oe  <= ~data_in[7];
              bit_cnt <= '0;
              state   <= SHIFT;
            end
          end
`endif
          SHIFT: begin
`ifdef I2C_SLAVE_CLOCK_STRETCH_EN
            // SCL is released one clk after SDA was set up in STRETCH.
            scl_oe_r <= 1'b0;
`endif
            if (scl_fall) begin
              if (bit_cnt == 3'd7) begin
                sda_oe <= 1'b0;
                acked  <= 1'b0;
                state  <= ACK;
              end else begin
                sda_oe  <= ~shreg[6];
                shreg   <= {shreg[5:0], 1'b0};
                bit_cnt <= bit_cnt + 3'd1;
              end
            end
          end
          ACK: begin
            if (!acked) begin
              if (scl_rise) begin
                if (!sda_s) begin
                  acked <= 1'b1;
                  if (byte_count != {COUNT_WIDTH{1'b1}})
                    byte_count <= byte_count + COUNT_WIDTH'(1);
                end else begin
                  nack  <= 1'b1;
                  done  <= 1'b1;
                  state <= IDLE;
                end
              end
            end else if (scl_fall) begin
              state <= LOAD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
